frame_reception: RTL and testbench
==================================

# frame_reception

Receive-side counterpart of the MAC frame transmitter. Consumes the byte stream the transmitter produces: seven-plus 0xAA preamble bytes, 0xAB SFD, 6-byte destination, 6-byte source, 2-byte EtherType, 4-byte payload and 4-byte CRC. It locates the SFD, de-serialises the header and payload fields, recomputes the CRC over the covered bytes and reports a good or bad frame with a one-cycle status pulse. It sits between the PHY-side byte interface and the MAC client logic.

## Interface
- MIN_PREAMBLE, 7: minimum count of consecutive 0xAA bytes required before the SFD; range 1..15.
- GAP_TIMEOUT, 16: consecutive idle (rx_dv=0) cycles tolerated inside a frame before it is aborted; range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_in  in  8  received byte; sampled only when rx_dv=1.
- rx_dv  in  1  byte valid qualifier.
- dest_addr  out  48  destination address of the last good frame; first received byte in [47:40].
- src_addr  out  48  source address of the last good frame; first byte in [47:40].
- eth_type  out  16  EtherType of the last good frame; first byte in [15:8].
- data_out  out  32  payload of the last good frame; first byte in [31:24].
- frame_valid  out  1  one-cycle pulse: frame received with matching CRC.
- crc_error  out  1  one-cycle pulse: frame complete, CRC mismatch.
- frame_abort  out  1  one-cycle pulse: frame dropped after SFD (gap timeout).
- rx_busy  out  1  high whenever state is not IDLE.
- state  out  4  current FSM state, for debug.

## Operation
- State encodings: IDLE=0, PREAMBLE=1, DEST_ADDR=3, SRC_ADDR=4, ETH_TYPE=5, PAYLOAD=6, FCS=7, CHECK=8. All values are distinct.
- Reset values: state=IDLE, every output 0, preamble counter 0, byte counter 0, gap counter 0, CRC register 0xFFFFFFFF.
- A "byte" is one rising edge with rx_dv=1. Edges with rx_dv=0 never advance the field counters.
- IDLE:
  - byte 0xAA: go to PREAMBLE with preamble count=1.
  - Any other byte: ignored.
- PREAMBLE:
  - 0xAA: increment the count; saturate at 15.
  - 0xAB with count>=MIN_PREAMBLE: go to DEST_ADDR, byte counter=0, CRC register=0xFFFFFFFF.
  - 0xAB with count<MIN_PREAMBLE: go to IDLE.
  - Any other byte: go to IDLE.
  - rx_dv=0 in PREAMBLE: go to IDLE. No abort pulse.
- Field states shift bytes into staging registers MSB-first, with byte counter wrap points:
  - DEST_ADDR: 6 bytes.
  - SRC_ADDR: 6 bytes.
  - ETH_TYPE: 2 bytes.
  - PAYLOAD: 4 bytes.
  - FCS: 4 bytes.
  - On wrap: move to the next state and clear the byte counter.
- Staging registers are internal. The output fields are loaded from staging only when frame_valid fires; they hold their value on crc_error and on frame_abort.
- CRC rules:
  - Standard Ethernet CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, bytes processed LSB-first, final XOR 0xFFFFFFFF.
  - Covers the 18 bytes from DEST_ADDR through PAYLOAD; FCS bytes are excluded.
  - The expected value is compared with the 4 received FCS bytes assembled as {fcs0,fcs1,fcs2,fcs3}, first received byte in [31:24].
  - The combinational per-byte update is allowed (no bit-serial).
- CHECK: lasts one cycle, whatever rx_dv is. It asserts exactly one of frame_valid or crc_error, then goes to IDLE. A byte presented during CHECK is ignored.
- Gap handling, DEST_ADDR..FCS:
  - The gap counter increments on each rx_dv=0 edge and clears on each byte.
  - When it reaches GAP_TIMEOUT: pulse frame_abort, go to IDLE, discard staging.
  - Gaps shorter than GAP_TIMEOUT are transparent. The transmitter idles rx_dv for at least one cycle before its CRC bytes.
- Reset asserted mid-frame: everything returns to reset values immediately; no pulse is produced.

## Timing
- Last FCS byte sampled at edge N: state=CHECK after N. At edge N+1, the frame_valid/crc_error pulse rises and the output fields update. At edge N+2, the pulse falls and state=IDLE.
- Minimum frame occupancy, rx_dv continuously high: MIN_PREAMBLE+1+22 byte cycles plus 1 CHECK cycle.
- frame_valid, crc_error and frame_abort are mutually exclusive and never high for more than one cycle.
- rx_busy is a registered function of state. It goes high the edge after the first 0xAA is accepted.

## Test plan
- Good frame:
  - Stimulus: 7×AA, AB, DA=0x001122334455, SA=0x66778899AABB, type=0x0800, payload=0xDEADBEEF, FCS from the bench CRC-32 model.
  - Required: frame_valid pulses once at N+1; outputs equal the sent values.
- Corrupt CRC:
  - Stimulus: same frame with the last FCS byte XOR 0x01.
  - Required: crc_error pulses once; outputs keep their previous values.
- Preamble faults:
  - Stimulus: AB after 6×AA with MIN_PREAMBLE=7; separately, a 0x55 inside the preamble.
  - Required: no pulses; state returns to IDLE; a following good frame is accepted.
- Gaps:
  - Stimulus: good frame with 3 idle cycles before the FCS, and with 15 idle cycles mid-payload.
  - Required: frame_valid.
  - Stimulus: 16 idle cycles mid-payload.
  - Required: frame_abort pulses once; rx_busy=0.
- Reset mid-frame:
  - Stimulus: assert rst during SRC_ADDR.
  - Required: all outputs 0 immediately; a good frame afterwards is received correctly.
- Back-to-back:
  - Stimulus: two good frames with the second preamble starting during CHECK.
  - Required: the CHECK-cycle byte is ignored; a second frame_valid arrives if 7 further AA bytes precede its SFD.

Source files
------------

// File: rtl/frame_reception.sv
// Receive-side MAC framer: locates the SFD, de-serialises the header and payload,
// recomputes the Ethernet CRC-32 and reports good, bad or aborted frames.
module frame_reception #(
    parameter int MIN_PREAMBLE = 7,
    parameter int GAP_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_in,
    input  logic        rx_dv,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [15:0] eth_type,
    output logic [31:0] data_out,
    output logic        frame_valid,
    output logic        crc_error,
    output logic        frame_abort,
    output logic        rx_busy,
    output logic [3:0]  state
);
    localparam logic [3:0]  ST_IDLE     = 4'd0;
    localparam logic [3:0]  ST_PREAMBLE = 4'd1;
    localparam logic [3:0]  ST_DEST     = 4'd3;
    localparam logic [3:0]  ST_SRC      = 4'd4;
    localparam logic [3:0]  ST_TYPE     = 4'd5;
    localparam logic [3:0]  ST_PAY      = 4'd6;
    localparam logic [3:0]  ST_FCS      = 4'd7;
    localparam logic [3:0]  ST_CHECK    = 4'd8;
    localparam logic [7:0]  PRE_BYTE    = 8'hAA;
    localparam logic [7:0]  SFD_BYTE    = 8'hAB;
    localparam logic [3:0]  MIN_PRE     = 4'(MIN_PREAMBLE);
    localparam logic [7:0]  GAP_LAST    = 8'(GAP_TIMEOUT - 1);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

    // Reflected CRC-32 update for one byte, least significant bit first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [3:0]  state_r;
    logic [3:0]  state_nx_s;
    logic [3:0]  pre_cnt_r;
    logic [2:0]  byte_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic [31:0] crc_r;
    logic [47:0] dest_stg_r;
    logic [47:0] src_stg_r;
    logic [15:0] type_stg_r;
    logic [31:0] pay_stg_r;
    logic [31:0] fcs_stg_r;
    logic        in_field_s;
    logic [2:0]  field_last_s;
    logic [3:0]  field_next_s;
    logic        field_wrap_s;
    logic        gap_expire_s;
    logic        crc_ok_s;
    logic        frame_valid_nx_s;
    logic        crc_error_nx_s;
    logic        frame_abort_nx_s;

    assign state = state_r;

    // Field length decode, gap expiry and CRC comparison.
    always_comb begin
        in_field_s   = 1'b1;
        field_last_s = 3'd0;
        field_next_s = ST_IDLE;
        case (state_r)
            ST_DEST: begin field_last_s = 3'd5; field_next_s = ST_SRC;   end
            ST_SRC:  begin field_last_s = 3'd5; field_next_s = ST_TYPE;  end
            ST_TYPE: begin field_last_s = 3'd1; field_next_s = ST_PAY;   end
            ST_PAY:  begin field_last_s = 3'd3; field_next_s = ST_FCS;   end
            ST_FCS:  begin field_last_s = 3'd3; field_next_s = ST_CHECK; end
            default: in_field_s = 1'b0;
        endcase
        field_wrap_s = in_field_s && rx_dv && (byte_cnt_r == field_last_s);
        gap_expire_s = in_field_s && !rx_dv && (gap_cnt_r == GAP_LAST);
        crc_ok_s     = ((~crc_r) == fcs_stg_r);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_dv && (rx_in == PRE_BYTE)) begin
                    state_nx_s = ST_PREAMBLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_nx_s = ST_IDLE;
                end else if (rx_in == PRE_BYTE) begin
                    state_nx_s = ST_PREAMBLE;
                end else if ((rx_in == SFD_BYTE) && (pre_cnt_r >= MIN_PRE)) begin
                    state_nx_s = ST_DEST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DEST, ST_SRC, ST_TYPE, ST_PAY, ST_FCS: begin
                if (gap_expire_s) begin
                    state_nx_s = ST_IDLE;
                end else if (field_wrap_s) begin
                    state_nx_s = field_next_s;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_CHECK: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Status pulse decode; the pulses themselves are registered below.
    always_comb begin
        frame_valid_nx_s = 1'b0;
        crc_error_nx_s   = 1'b0;
        if (state_r == ST_CHECK) begin
            frame_valid_nx_s = crc_ok_s;
            crc_error_nx_s   = !crc_ok_s;
        end else begin
            frame_valid_nx_s = 1'b0;
            crc_error_nx_s   = 1'b0;
        end
        frame_abort_nx_s = gap_expire_s;
    end

    // Counters, CRC accumulator and field staging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r  <= 4'd0;
            byte_cnt_r <= 3'd0;
            gap_cnt_r  <= 8'd0;
            crc_r      <= CRC_INIT;
            dest_stg_r <= 48'd0;
            src_stg_r  <= 48'd0;
            type_stg_r <= 16'd0;
            pay_stg_r  <= 32'd0;
            fcs_stg_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pre_cnt_r  <= (rx_dv && (rx_in == PRE_BYTE)) ? 4'd1 : 4'd0;
                    byte_cnt_r <= 3'd0;
                    gap_cnt_r  <= 8'd0;
                end
                ST_PREAMBLE: begin
                    if (state_nx_s == ST_PREAMBLE) begin
                        pre_cnt_r <= (pre_cnt_r == 4'd15) ? 4'd15 : pre_cnt_r + 4'd1;
                    end else begin
                        pre_cnt_r <= 4'd0;
                    end
                    byte_cnt_r <= 3'd0;
                    gap_cnt_r  <= 8'd0;
                    crc_r      <= CRC_INIT;
                end
                ST_DEST, ST_SRC, ST_TYPE, ST_PAY, ST_FCS: begin
                    if (rx_dv) begin
                        gap_cnt_r  <= 8'd0;
                        byte_cnt_r <= field_wrap_s ? 3'd0 : byte_cnt_r + 3'd1;
                        if (state_r != ST_FCS) begin
                            crc_r <= crc32_byte(crc_r, rx_in);
                        end
                        case (state_r)
                            ST_DEST: dest_stg_r <= {dest_stg_r[39:0], rx_in};
                            ST_SRC:  src_stg_r  <= {src_stg_r[39:0], rx_in};
                            ST_TYPE: type_stg_r <= {type_stg_r[7:0], rx_in};
                            ST_PAY:  pay_stg_r  <= {pay_stg_r[23:0], rx_in};
                            ST_FCS:  fcs_stg_r  <= {fcs_stg_r[23:0], rx_in};
                            default: fcs_stg_r  <= fcs_stg_r;
                        endcase
                    end else if (gap_expire_s) begin
                        gap_cnt_r  <= 8'd0;
                        byte_cnt_r <= 3'd0;
                        crc_r      <= CRC_INIT;
                        dest_stg_r <= 48'd0;
                        src_stg_r  <= 48'd0;
                        type_stg_r <= 16'd0;
                        pay_stg_r  <= 32'd0;
                        fcs_stg_r  <= 32'd0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    byte_cnt_r <= 3'd0;
                    gap_cnt_r  <= 8'd0;
                end
            endcase
        end
    end

    // Registered status and output fields; fields load only on a good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            crc_error   <= 1'b0;
            frame_abort <= 1'b0;
            rx_busy     <= 1'b0;
            dest_addr   <= 48'd0;
            src_addr    <= 48'd0;
            eth_type    <= 16'd0;
            data_out    <= 32'd0;
        end else begin
            frame_valid <= frame_valid_nx_s;
            crc_error   <= crc_error_nx_s;
            frame_abort <= frame_abort_nx_s;
            rx_busy     <= (state_r != ST_IDLE);
            if (frame_valid_nx_s) begin
                dest_addr <= dest_stg_r;
                src_addr  <= src_stg_r;
                eth_type  <= type_stg_r;
                data_out  <= pay_stg_r;
            end
        end
    end
endmodule

// File: tb/tb_frame_reception.sv
// Directed bench for frame_reception: good, corrupt, preamble faults, gaps,
// mid-frame reset and back-to-back frames, with a CRC-32 reference model.
module tb_frame_reception;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_in = 8'd0;
    logic        rx_dv = 1'b0;
    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic [31:0] data_out;
    logic        frame_valid;
    logic        crc_error;
    logic        frame_abort;
    logic        rx_busy;
    logic [3:0]  state;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;
    int ce_cnt = 0;
    int fa_cnt = 0;

    localparam logic [47:0] DA_A = 48'h0011_2233_4455;
    localparam logic [47:0] SA_A = 48'h6677_8899_AABB;
    localparam logic [15:0] TY_A = 16'h0800;
    localparam logic [31:0] PL_A = 32'hDEAD_BEEF;
    localparam logic [47:0] DA_B = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] SA_B = 48'h1020_3040_5060;
    localparam logic [15:0] TY_B = 16'h86DD;
    localparam logic [31:0] PL_B = 32'hCAFE_F00D;
    localparam logic [31:0] PL_C = 32'h1234_5678;

    always #5 clk = ~clk;

    frame_reception #(.MIN_PREAMBLE(7), .GAP_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_dv(rx_dv),
        .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type), .data_out(data_out),
        .frame_valid(frame_valid), .crc_error(crc_error), .frame_abort(frame_abort),
        .rx_busy(rx_busy), .state(state)
    );

    function automatic logic [31:0] frame_fcs(input logic [47:0] da, input logic [47:0] sa,
                                              input logic [15:0] ty, input logic [31:0] pl);
        logic [143:0] hdr;
        logic [31:0]  c;
        hdr = {da, sa, ty, pl};
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 18; i++) begin
            c = c ^ {24'd0, hdr[143-8*i -: 8]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // One clock: sample outputs at the falling edge, tally pulses, then drive.
    task automatic cycle(input logic dv, input logic [7:0] b);
        @(negedge clk);
        if (frame_valid) fv_cnt++;
        if (crc_error) ce_cnt++;
        if (frame_abort) fa_cnt++;
        rx_dv = dv;
        rx_in = b;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        fv_cnt = 0; ce_cnt = 0; fa_cnt = 0;
    endtask

    task automatic send_frame(input int npre, input logic [47:0] da, input logic [47:0] sa,
                              input logic [15:0] ty, input logic [31:0] pl, input logic [7:0] fcs_xor,
                              input int gap_pos, input int gap_len, input bit stop_at_gap);
        logic [7:0]   b [22];
        logic [175:0] all;
        logic [31:0]  fcs;
        fcs = frame_fcs(da, sa, ty, pl);
        all = {da, sa, ty, pl, fcs};
        for (int i = 0; i < 22; i++) b[i] = all[175-8*i -: 8];
        b[21] = b[21] ^ fcs_xor;
        repeat (npre) cycle(1'b1, 8'hAA);
        cycle(1'b1, 8'hAB);
        for (int i = 0; i < 22; i++) begin
            if (i == gap_pos) begin
                repeat (gap_len) cycle(1'b0, 8'h00);
                if (stop_at_gap) return;
            end
            cycle(1'b1, b[i]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0h exp=0", state); end
        checks++; if ({frame_valid, crc_error, frame_abort, rx_busy} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got=%b exp=0000", {frame_valid, crc_error, frame_abort, rx_busy}); end
        checks++; if ({dest_addr, src_addr, eth_type, data_out} !== 144'd0) begin failures++;
            $display("FAIL reset_fields got=%h exp=0", {dest_addr, src_addr, eth_type, data_out}); end
        rst = 1'b0;
        drain(2);
    endtask

    task automatic test_good_frame();
        clear_counts();
        cycle(1'b1, 8'hAA);
        cycle(1'b1, 8'hAA);
        checks++; if (state !== 4'd1) begin failures++; $display("FAIL good_pre_state got=%0h exp=1", state); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL good_busy_lag got=%b exp=0", rx_busy); end
        cycle(1'b1, 8'hAA);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL good_busy_high got=%b exp=1", rx_busy); end
        send_frame(4, DA_A, SA_A, TY_A, PL_A, 8'h00, -1, 0, 1'b0);
        cycle(1'b0, 8'h00);
        checks++; if ({state, frame_valid} !== {4'd8, 1'b0}) begin failures++;
            $display("FAIL good_check_cycle got=%0h/%b exp=8/0", state, frame_valid); end
        cycle(1'b0, 8'h00);
        checks++; if ({frame_valid, crc_error, state} !== {1'b1, 1'b0, 4'd0}) begin failures++;
            $display("FAIL good_pulse got=%b/%b/%0h exp=1/0/0", frame_valid, crc_error, state); end
        checks++; if ({dest_addr, src_addr, eth_type, data_out} !== {DA_A, SA_A, TY_A, PL_A}) begin failures++;
            $display("FAIL good_fields got=%h exp=%h", {dest_addr, src_addr, eth_type, data_out}, {DA_A, SA_A, TY_A, PL_A}); end
        cycle(1'b0, 8'h00);
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL good_pulse_fall got=%b exp=0", frame_valid); end
        drain(2);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt} !== {32'd1, 32'd0, 32'd0}) begin failures++;
            $display("FAIL good_counts got=%0d/%0d/%0d exp=1/0/0", fv_cnt, ce_cnt, fa_cnt); end
    endtask

    task automatic test_corrupt_crc();
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_C, 8'h01, -1, 0, 1'b0);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        checks++; if ({crc_error, frame_valid} !== 2'b10) begin failures++;
            $display("FAIL crc_pulse got=%b/%b exp=1/0", crc_error, frame_valid); end
        drain(3);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt} !== {32'd0, 32'd1, 32'd0}) begin failures++;
            $display("FAIL crc_counts got=%0d/%0d/%0d exp=0/1/0", fv_cnt, ce_cnt, fa_cnt); end
        checks++; if ({dest_addr, data_out} !== {DA_A, PL_A}) begin failures++;
            $display("FAIL crc_hold got=%h exp=%h", {dest_addr, data_out}, {DA_A, PL_A}); end
    endtask

    task automatic test_preamble_faults();
        clear_counts();
        repeat (6) cycle(1'b1, 8'hAA);
        send_frame(0, DA_B, SA_B, TY_B, PL_B, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt, 28'd0, state} !== 128'd0) begin failures++;
            $display("FAIL pre_short got=%0d/%0d/%0d st=%0h exp=0/0/0 st=0", fv_cnt, ce_cnt, fa_cnt, state); end
        repeat (3) cycle(1'b1, 8'hAA);
        cycle(1'b1, 8'h55);
        send_frame(4, DA_B, SA_B, TY_B, PL_B, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt, 28'd0, state} !== 128'd0) begin failures++;
            $display("FAIL pre_bad_byte got=%0d/%0d/%0d st=%0h exp=0/0/0 st=0", fv_cnt, ce_cnt, fa_cnt, state); end
        send_frame(7, DA_B, SA_B, TY_B, PL_B, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if (fv_cnt !== 1) begin failures++; $display("FAIL pre_recover got=%0d exp=1", fv_cnt); end
        checks++; if ({dest_addr, src_addr, eth_type, data_out} !== {DA_B, SA_B, TY_B, PL_B}) begin failures++;
            $display("FAIL pre_recover_fields got=%h exp=%h", {dest_addr, src_addr, eth_type, data_out}, {DA_B, SA_B, TY_B, PL_B}); end
    endtask

    task automatic test_gaps();
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, 18, 3, 1'b0);
        drain(4);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt} !== {32'd1, 32'd0, 32'd0} || data_out !== PL_A) begin failures++;
            $display("FAIL gap3_fcs got=%0d/%0d/%0d %h exp=1/0/0 %h", fv_cnt, ce_cnt, fa_cnt, data_out, PL_A); end
        clear_counts();
        send_frame(7, DA_B, SA_B, TY_B, PL_B, 8'h00, 16, 15, 1'b0);
        drain(4);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt} !== {32'd1, 32'd0, 32'd0} || dest_addr !== DA_B) begin failures++;
            $display("FAIL gap15_payload got=%0d/%0d/%0d %h exp=1/0/0 %h", fv_cnt, ce_cnt, fa_cnt, dest_addr, DA_B); end
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, 16, 16, 1'b1);
        cycle(1'b0, 8'h00);
        checks++; if ({frame_abort, state} !== {1'b1, 4'd0}) begin failures++;
            $display("FAIL gap16_pulse got=%b/%0h exp=1/0", frame_abort, state); end
        drain(3);
        checks++; if ({fv_cnt, ce_cnt, fa_cnt} !== {32'd0, 32'd0, 32'd1}) begin failures++;
            $display("FAIL gap16_counts got=%0d/%0d/%0d exp=0/0/1", fv_cnt, ce_cnt, fa_cnt); end
        checks++; if ({rx_busy, dest_addr} !== {1'b0, DA_B}) begin failures++;
            $display("FAIL gap16_idle got=%b/%h exp=0/%h", rx_busy, dest_addr, DA_B); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, 8, 0, 1'b1);
        cycle(1'b1, 8'h00);
        checks++; if (state !== 4'd4) begin failures++; $display("FAIL rst_mid_state got=%0h exp=4", state); end
        rst = 1'b1;
        #1;
        checks++; if ({dest_addr, src_addr, eth_type, data_out, frame_valid, crc_error, frame_abort, rx_busy, state} !== 152'd0) begin
            failures++; $display("FAIL rst_mid_outputs got=%h exp=0",
                {dest_addr, src_addr, eth_type, data_out, frame_valid, crc_error, frame_abort, rx_busy, state}); end
        @(negedge clk);
        rst = 1'b0;
        rx_dv = 1'b0;
        drain(2);
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if (fv_cnt !== 1 || {dest_addr, src_addr, eth_type, data_out} !== {DA_A, SA_A, TY_A, PL_A}) begin failures++;
            $display("FAIL rst_recover got=%0d %h exp=1 %h", fv_cnt, {dest_addr, src_addr, eth_type, data_out}, {DA_A, SA_A, TY_A, PL_A}); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, -1, 0, 1'b0);
        cycle(1'b1, 8'hAA);
        send_frame(7, DA_B, SA_B, TY_B, PL_B, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if (fv_cnt !== 2 || {dest_addr, data_out} !== {DA_B, PL_B}) begin failures++;
            $display("FAIL b2b_seven got=%0d %h exp=2 %h", fv_cnt, {dest_addr, data_out}, {DA_B, PL_B}); end
        clear_counts();
        send_frame(7, DA_A, SA_A, TY_A, PL_A, 8'h00, -1, 0, 1'b0);
        cycle(1'b1, 8'hAA);
        send_frame(6, DA_B, SA_B, TY_B, PL_B, 8'h00, -1, 0, 1'b0);
        drain(4);
        checks++; if (fv_cnt !== 1 || {dest_addr, data_out} !== {DA_A, PL_A}) begin failures++;
            $display("FAIL b2b_six got=%0d %h exp=1 %h", fv_cnt, {dest_addr, data_out}, {DA_A, PL_A}); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_corrupt_crc();
        test_preamble_faults();
        test_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
